// File: rtl/chip_test_engine.sv
// -----------------------------------------------------------------------------
// chip_test_engine
//
// Exercises a quad 2-input logic chip (7400/7402/7408/7432/7486/7404) with the
// four input combinations and reports which gates disagree with the expected
// truth table. Each vector is driven onto every gate at once. The vector is
// held for SETTLE_CYCLES cycles. The synchronized readback is then compared
// once per vector.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before sampling (3..15, default 4)
//
// Configuration macro
//   CHIP_TEST_STOP_ON_FAIL_EN  when defined, the first vector with any mismatch
//                              ends the test. Fail_Gate then holds only that
//                              vector's mismatches. When undefined, all four
//                              vectors run and Fail_Gate accumulates.
//
// Ports
//   Clk          in   system clock, rising-edge
//   Reset        in   synchronous active-high reset
//   Start_Check  in   level request to (re)start a test; aborts a running test
//   LD_SW        in   qualifies loading SW into the selection register
//   SW[2:0]      in   chip type: 0 NAND, 1 NOR, 2 AND, 3 OR, 4 XOR, 5 NOT
//   DUT_OUT[3:0] in   gate outputs from the chip under test (asynchronous)
//   DUT_IN[7:0]  out  stimulus; gate g: A = DUT_IN[2g], B = DUT_IN[2g+1]
//   DUT_EN       out  stimulus drive enable
//   Check_Done   out  result valid
//   Pass         out  chip passed (valid with Check_Done)
//   Fail_Gate    out  per-gate failure mask
//   Fail_Vec     out  index of the first failing vector
//   Bad_Sel      out  latched chip type was unsupported
// -----------------------------------------------------------------------------
module chip_test_engine #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start_Check,
    input  logic       LD_SW,
    input  logic [2:0] SW,
    input  logic [3:0] DUT_OUT,
    output logic [7:0] DUT_IN,
    output logic       DUT_EN,
    output logic       Check_Done,
    output logic       Pass,
    output logic [3:0] Fail_Gate,
    output logic [1:0] Fail_Vec,
    output logic       Bad_Sel
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state, next_state;

    logic [2:0] sel_q;        // latched chip type
    logic [1:0] vec_q;        // vector counter v
    logic [3:0] settle_q;     // cycles spent in SETTLE for the current vector
    logic [3:0] sync1_q;      // synchronizer stage 1
    logic [3:0] sync2_q;      // synchronizer stage 2
    logic [3:0] fail_gate_q;
    logic [1:0] fail_vec_q;
    logic       bad_sel_q;

    logic       vec_a;
    logic       vec_b;
    logic       exp_bit;
    logic       sel_valid;
    logic       settle_last;
    logic [3:0] mismatch;

    assign vec_a       = vec_q[0];
    assign vec_b       = vec_q[1];
    assign sel_valid   = (sel_q <= 3'd5);
    assign settle_last = (settle_q == SETTLE_LAST);

    // Every gate sees the same A/B, so one expected bit covers all four gates.
    always_comb begin
        case (sel_q)
            3'd0:    exp_bit = ~(vec_a & vec_b);
            3'd1:    exp_bit = ~(vec_a | vec_b);
            3'd2:    exp_bit = vec_a & vec_b;
            3'd3:    exp_bit = vec_a | vec_b;
            3'd4:    exp_bit = vec_a ^ vec_b;
            3'd5:    exp_bit = ~vec_a;
            default: exp_bit = 1'b0;
        endcase
    end

    assign mismatch = sync2_q ^ {4{exp_bit}};

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and outputs
    // ---------------------------------------------------------------------
    // NOTE: every output gets a default before the case statement so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        DUT_IN     = '0;
        DUT_EN     = 1'b0;
        Check_Done = 1'b0;
        Pass       = 1'b0;

        case (state)
            IDLE: begin
                next_state = IDLE;
            end
            LOAD: begin
                next_state = sel_valid ? SETTLE : DONE;
            end
            SETTLE: begin
                DUT_EN = 1'b1;
                DUT_IN = {4{vec_b, vec_a}};
                if (settle_last) begin
                    next_state = SAMPLE;
                end
            end
            SAMPLE: begin
                DUT_EN = 1'b1;
                DUT_IN = {4{vec_b, vec_a}};
`ifdef CHIP_TEST_STOP_ON_FAIL_EN
                if (mismatch != 4'b0000 || vec_q == 2'd3) begin
                    next_state = DONE;
                end else begin
                    next_state = SETTLE;
                end
`else
                next_state = (vec_q == 2'd3) ? DONE : SETTLE;
`endif
            end
            DONE: begin
                Check_Done = 1'b1;
                Pass       = (fail_gate_q == 4'b0000) && !bad_sel_q;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // A start request overrides any state, aborting a test in progress.
        if (Start_Check) begin
            next_state = LOAD;
        end
    end

    // ---------------------------------------------------------------------
    // Datapath: selection, counters, synchronizer, result registers
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sel_q       <= '0;
            vec_q       <= '0;
            settle_q    <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            fail_gate_q <= '0;
            fail_vec_q  <= '0;
            bad_sel_q   <= 1'b0;
        end else begin
            sync1_q <= DUT_OUT;
            sync2_q <= sync1_q;

            if (Start_Check && LD_SW) begin
                sel_q <= SW;
            end

            if (Start_Check) begin
                // Clearing on the request edge makes results read as zero
                // throughout the LOAD cycle.
                vec_q       <= '0;
                settle_q    <= '0;
                fail_gate_q <= '0;
                fail_vec_q  <= '0;
                bad_sel_q   <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        vec_q    <= '0;
                        settle_q <= '0;
                        if (!sel_valid) begin
                            bad_sel_q <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        settle_q <= settle_last ? 4'd0 : settle_q + 4'd1;
                    end
                    SAMPLE: begin
                        fail_gate_q <= fail_gate_q | mismatch;
                        // An empty mask means no earlier vector has failed.
                        if (mismatch != 4'b0000 && fail_gate_q == 4'b0000) begin
                            fail_vec_q <= vec_q;
                        end
                        if (next_state == SETTLE) begin
                            vec_q <= vec_q + 2'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign Fail_Gate = fail_gate_q;
    assign Fail_Vec  = fail_vec_q;
    assign Bad_Sel   = bad_sel_q;

endmodule
